// File: rtl/chip_emu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : chip_emu_pkg
// Purpose  : Shared types and constants for the 74161 chip emulator:
//            - fault injection select encoding
//            - index positions of the filtered input pins
//            - upper limit for the glitch filter length
// Revision : 1.0 - initial release
// ============================================================================
package chip_emu_pkg;

  typedef enum logic [2:0] {
    FLT_NONE    = 3'd0,
    FLT_QA_SA0  = 3'd1,
    FLT_QD_SA1  = 3'd2,
    FLT_RCO_SA0 = 3'd3,
    FLT_SKIP    = 3'd4
  } fault_e;

  // Bit positions of the input pins inside the filtered pin vectors
  localparam int c_PIN_CLR  = 0;  // Pin1  CLR_n
  localparam int c_PIN_CLK  = 1;  // Pin2  CLK
  localparam int c_PIN_A    = 2;  // Pin3  A (LSB)
  localparam int c_PIN_B    = 3;  // Pin4  B
  localparam int c_PIN_C    = 4;  // Pin5  C
  localparam int c_PIN_D    = 5;  // Pin6  D
  localparam int c_PIN_ENP  = 6;  // Pin7  ENP
  localparam int c_PIN_LOAD = 7;  // Pin9  LOAD_n
  localparam int c_PIN_ENT  = 8;  // Pin10 ENT
  localparam int c_NUM_PINS = 9;

  localparam int MAX_FILT_LEN = 15;

  // Unused encodings 5..7 fall back to a healthy device
  function automatic fault_e decode_fault(input logic [2:0] sel);
    fault_e f;
    f = FLT_NONE;
    case (sel)
      3'd1:    f = FLT_QA_SA0;
      3'd2:    f = FLT_QD_SA1;
      3'd3:    f = FLT_RCO_SA0;
      3'd4:    f = FLT_SKIP;
      default: f = FLT_NONE;
    endcase
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/chip_emu_74161_filter.sv
`default_nettype none
// ============================================================================
// Module   : pin_sync_filter
// Purpose  : Synchronizes one asynchronous pin and filters it so that the
//            filtered level only changes after FILT_LEN identical samples.
//            The first stable level after reset arms the filter silently.
// Ports    : clk    - system clock
//            rst_n  - asynchronous active-low reset
//            i_pin  - raw pin input
//            level  - filtered pin level
//            rise   - one-cycle pulse on an accepted filtered rising edge
//            armed  - filter has seen its first stable level since reset
// Revision : 1.0 - initial release
// ============================================================================
module pin_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  output logic level,
  output logic rise,
  output logic armed
);

  localparam logic [3:0] c_FILT_LEN = 4'(FILT_LEN);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_vld;   // marks when reset zeros have left the chain
  logic                   r_last;
  logic [3:0]             r_run;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_armed;

  logic       w_s;
  logic       w_valid;
  logic [3:0] w_run_next;
  logic       w_stable;

  assign w_s     = r_sync[SYNC_STAGES-1];
  assign w_valid = r_vld[SYNC_STAGES-1];

  // Length of the current run of identical samples, saturating at FILT_LEN
  always_comb begin
    w_run_next = 4'd1;
    if (r_run != 4'd0 && w_s == r_last) begin
      w_run_next = (r_run >= c_FILT_LEN) ? r_run : r_run + 4'd1;
    end
  end

  assign w_stable = (w_run_next >= c_FILT_LEN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_vld   <= '0;
      r_last  <= 1'b0;
      r_run   <= 4'd0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_vld  <= {r_vld[SYNC_STAGES-2:0], 1'b1};
      r_rise <= 1'b0;
      if (w_valid) begin
        r_last <= w_s;
        r_run  <= w_run_next;
        if (w_stable) begin
          r_armed <= 1'b1;
          r_level <= w_s;
          // The arming sample itself never produces an edge
          r_rise  <= r_armed & ~r_level & w_s;
        end
      end
    end
  end

  assign level = r_level;
  assign rise  = r_rise;
  assign armed = r_armed;

endmodule
`default_nettype wire

// File: rtl/chip_emu_74161.sv
`default_nettype none
// ============================================================================
// Module   : chip_emu_74161
// Purpose  : Pin-level emulator of a 74161 4-bit synchronous binary counter
//            with selectable output fault injection.
// Ports    : Clk, Reset       - 50 MHz system clock, async active-low reset
//            Enable           - 1 drives Pin11..Pin15, 0 releases them (Z)
//            Fault_Sel        - fault injection select (fault_e)
//            Pin1..Pin10      - CLR_n, CLK, A, B, C, D, ENP, LOAD_n, ENT
//            Pin11..Pin15     - QD, QC, QB, QA, RCO (tri-state)
//            Count            - internal Q before fault injection
//            Edge_Cnt         - accepted CLK rising edges, wraps at 255
// Revision : 1.0 - initial release
// ============================================================================
module chip_emu_74161
  import chip_emu_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Enable,
  input  logic [2:0] Fault_Sel,
  input  logic       Pin1,
  input  logic       Pin2,
  input  logic       Pin3,
  input  logic       Pin4,
  input  logic       Pin5,
  input  logic       Pin6,
  input  logic       Pin7,
  input  logic       Pin9,
  input  logic       Pin10,
  inout  wire        Pin11,
  inout  wire        Pin12,
  inout  wire        Pin13,
  inout  wire        Pin14,
  inout  wire        Pin15,
  output logic [3:0] Count,
  output logic [7:0] Edge_Cnt
);

  logic [c_NUM_PINS-1:0] w_pin_raw;
  logic [c_NUM_PINS-1:0] w_level;
  logic [c_NUM_PINS-1:0] w_rise;
  logic [c_NUM_PINS-1:0] w_armed;

  assign w_pin_raw[c_PIN_CLR]  = Pin1;
  assign w_pin_raw[c_PIN_CLK]  = Pin2;
  assign w_pin_raw[c_PIN_A]    = Pin3;
  assign w_pin_raw[c_PIN_B]    = Pin4;
  assign w_pin_raw[c_PIN_C]    = Pin5;
  assign w_pin_raw[c_PIN_D]    = Pin6;
  assign w_pin_raw[c_PIN_ENP]  = Pin7;
  assign w_pin_raw[c_PIN_LOAD] = Pin9;
  assign w_pin_raw[c_PIN_ENT]  = Pin10;

  for (genvar gi = 0; gi < c_NUM_PINS; gi++) begin : g_pin
    pin_sync_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN)
    ) u_filt (
      .clk   (Clk),
      .rst_n (Reset),
      .i_pin (w_pin_raw[gi]),
      .level (w_level[gi]),
      .rise  (w_rise[gi]),
      .armed (w_armed[gi])
    );
  end

  // Only the CLK filter's edge output and the data pins' levels matter
  logic w_unused;
  assign w_unused = ^{w_rise[c_NUM_PINS-1:c_PIN_CLK+1], w_rise[c_PIN_CLK-1:0],
                      w_level[c_PIN_CLK]};

  logic       w_clr_n;
  logic       w_load_n;
  logic       w_enp;
  logic       w_ent;
  logic [3:0] w_data;
  logic       w_edge;

  assign w_clr_n  = w_level[c_PIN_CLR];
  assign w_load_n = w_level[c_PIN_LOAD];
  assign w_enp    = w_level[c_PIN_ENP];
  assign w_ent    = w_level[c_PIN_ENT];
  assign w_data   = {w_level[c_PIN_D], w_level[c_PIN_C],
                     w_level[c_PIN_B], w_level[c_PIN_A]};
  // No edge is trusted until every pin has a known, filtered level
  assign w_edge   = w_rise[c_PIN_CLK] & (&w_armed);

  fault_e     r_fault;
  logic       r_en;
  logic [3:0] r_q;
  logic [7:0] r_edge_cnt;
  logic [3:0] r_out_q;
  logic       r_out_rco;

  logic [3:0] w_step;
  logic       w_rco;
  logic [3:0] w_out_q;
  logic       w_out_rco;

  // The skip fault is the one fault that corrupts the internal count
  assign w_step = (r_fault == FLT_SKIP) ? 4'd2 : 4'd1;
  assign w_rco  = w_ent & (r_q == 4'hF);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_fault    <= FLT_NONE;
      r_en       <= 1'b0;
      r_q        <= 4'd0;
      r_edge_cnt <= 8'd0;
    end else begin
      r_fault <= decode_fault(Fault_Sel);
      r_en    <= Enable;
      if (w_edge) begin
        r_edge_cnt <= r_edge_cnt + 8'd1;
      end
      // Clear is level-sensitive and beats a coincident edge
      if (!w_clr_n) begin
        r_q <= 4'd0;
      end else if (w_edge) begin
        if (!w_load_n) begin
          r_q <= w_data;
        end else if (w_enp && w_ent) begin
          r_q <= r_q + w_step;
        end
      end
    end
  end

  always_comb begin
    w_out_q   = r_q;
    w_out_rco = w_rco;
    case (r_fault)
      FLT_QA_SA0:  w_out_q[0] = 1'b0;
      FLT_QD_SA1:  w_out_q[3] = 1'b1;
      FLT_RCO_SA0: w_out_rco  = 1'b0;
      default:     ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_out_q   <= 4'd0;
      r_out_rco <= 1'b0;
    end else begin
      r_out_q   <= w_out_q;
      r_out_rco <= w_out_rco;
    end
  end

  assign Pin11 = r_en ? r_out_q[3] : 1'bz;
  assign Pin12 = r_en ? r_out_q[2] : 1'bz;
  assign Pin13 = r_en ? r_out_q[1] : 1'bz;
  assign Pin14 = r_en ? r_out_q[0] : 1'bz;
  assign Pin15 = r_en ? r_out_rco  : 1'bz;

  assign Count    = r_q;
  assign Edge_Cnt = r_edge_cnt;

endmodule
`default_nettype wire

// File: tb/tb_chip_emu_74161.sv
`default_nettype none
// ============================================================================
// Module   : tb_chip_emu_74161
// Purpose  : Self-checking bench for chip_emu_74161: a directed vector table,
//            hand-written corner sequences and a randomized phase scored
//            against a pin-level behavioural model of the 74161.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chip_emu_74161;

  localparam int c_FILT = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [2:0] fsel;
  logic       p1, p2, p3, p4, p5, p6, p7, p9, p10;
  wire        p11, p12, p13, p14, p15;
  logic [3:0] cnt;
  logic [7:0] ecnt;

  // Pull-ups make a released (Z) pin observable as 1
  pullup (p11);
  pullup (p12);
  pullup (p13);
  pullup (p14);
  pullup (p15);

  always #10 clk = ~clk;

  chip_emu_74161 #(.SYNC_STAGES(2), .FILT_LEN(c_FILT)) dut (
    .Clk(clk), .Reset(rst_n), .Enable(en), .Fault_Sel(fsel),
    .Pin1(p1), .Pin2(p2), .Pin3(p3), .Pin4(p4), .Pin5(p5), .Pin6(p6),
    .Pin7(p7), .Pin9(p9), .Pin10(p10),
    .Pin11(p11), .Pin12(p12), .Pin13(p13), .Pin14(p14), .Pin15(p15),
    .Count(cnt), .Edge_Cnt(ecnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // {RCO, QD, QC, QB, QA} as seen on the pins
  function automatic int rd_pins();
    logic [4:0] v;
    v = {p15, p11, p12, p13, p14};
    return int'(v);
  endfunction

  // What the pins must show for a given count, ENT and fault select
  function automatic int exp_pins(input int q, input bit ent, input int f);
    int rco;
    int qv;
    rco = (ent && q == 15) ? 1 : 0;
    qv  = q;
    if (f == 1) qv  = qv & 14;
    if (f == 2) qv  = qv | 8;
    if (f == 3) rco = 0;
    return rco * 16 + qv;
  endfunction

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input bit clr, input bit ld, input bit enp, input bit ent,
                       input logic [3:0] d, input logic [2:0] f);
    @(negedge clk);
    p1 = clr; p9 = ld; p7 = enp; p10 = ent;
    {p6, p5, p4, p3} = d;
    fsel = f;
    wait_n(12);
  endtask

  task automatic pulse(input int h);
    if (h > 0) begin
      p2 = 1'b1;
      wait_n(h);
      p2 = 1'b0;
      wait_n(20);
    end
  endtask

  typedef struct {
    bit         clr, ld, enp, ent;
    logic [3:0] d;
    logic [2:0] f;
    int         h;
    int         q;
    int         e;
    logic [4:0] pins;
  } vec_t;

  vec_t tbl[27];

  int         m_q, m_e;
  int         hw[5] = '{2, 3, 4, 5, 20};

  initial begin : wd
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    tbl[0]  = '{1,1,1,1,4'h0,3'd0,20, 1, 1,5'b00001};
    tbl[1]  = '{1,1,1,1,4'h0,3'd0,20, 2, 2,5'b00010};
    tbl[2]  = '{1,1,1,1,4'h0,3'd0,20, 3, 3,5'b00011};
    tbl[3]  = '{1,1,1,1,4'h0,3'd0,20, 4, 4,5'b00100};
    tbl[4]  = '{1,0,1,1,4'hD,3'd0,20,13, 5,5'b01101};
    tbl[5]  = '{1,1,1,1,4'hD,3'd0,20,14, 6,5'b01110};
    tbl[6]  = '{1,1,1,1,4'hD,3'd0,20,15, 7,5'b11111};
    tbl[7]  = '{1,1,1,1,4'hD,3'd0,20, 0, 8,5'b00000};
    tbl[8]  = '{1,0,1,0,4'hF,3'd0,20,15, 9,5'b01111};
    tbl[9]  = '{1,1,0,1,4'hF,3'd0, 0,15, 9,5'b11111};
    tbl[10] = '{1,1,0,1,4'hF,3'd0,20,15,10,5'b11111};
    tbl[11] = '{1,1,1,1,4'hF,3'd0, 2,15,10,5'b11111};
    tbl[12] = '{1,1,1,1,4'hF,3'd0, 3,15,10,5'b11111};
    tbl[13] = '{1,1,1,1,4'hF,3'd0, 4, 0,11,5'b00000};
    tbl[14] = '{1,1,1,1,4'h0,3'd1,20, 1,12,5'b00000};
    tbl[15] = '{1,1,1,1,4'h0,3'd1,20, 2,13,5'b00010};
    tbl[16] = '{1,1,1,1,4'h0,3'd1,20, 3,14,5'b00010};
    tbl[17] = '{1,1,1,1,4'h0,3'd2, 0, 3,14,5'b01011};
    tbl[18] = '{1,0,1,1,4'hF,3'd3,20,15,15,5'b01111};
    tbl[19] = '{1,1,1,1,4'hF,3'd0, 0,15,15,5'b11111};
    tbl[20] = '{1,1,1,1,4'hF,3'd5, 0,15,15,5'b11111};
    tbl[21] = '{1,0,1,1,4'h0,3'd4,20, 0,16,5'b00000};
    tbl[22] = '{1,1,1,1,4'h0,3'd4,20, 2,17,5'b00010};
    tbl[23] = '{1,1,1,1,4'h0,3'd4,20, 4,18,5'b00100};
    tbl[24] = '{1,1,1,1,4'h0,3'd4,20, 6,19,5'b00110};
    tbl[25] = '{0,1,1,1,4'h0,3'd0,20, 0,20,5'b00000};
    tbl[26] = '{1,1,1,1,4'h0,3'd0,20, 1,21,5'b00001};

    // Reset with the CLK pin held high
    rst_n = 1'b0; en = 1'b1; fsel = 3'd0;
    p1 = 1; p2 = 1; p3 = 0; p4 = 0; p5 = 0; p6 = 0; p7 = 1; p9 = 1; p10 = 1;
    wait_n(5);
    chk("reset_count", int'(cnt), 0);
    chk("reset_edges", int'(ecnt), 0);
    rst_n = 1'b1;
    wait_n(20);
    chk("held_high_count", int'(cnt), 0);
    chk("held_high_edges", int'(ecnt), 0);
    chk("held_high_pins", rd_pins(), 0);
    p2 = 1'b0;
    wait_n(20);
    chk("fall_count", int'(cnt), 0);
    chk("fall_edges", int'(ecnt), 0);

    // Directed vector table
    for (int i = 0; i < 27; i++) begin
      drive(tbl[i].clr, tbl[i].ld, tbl[i].enp, tbl[i].ent, tbl[i].d, tbl[i].f);
      pulse(tbl[i].h);
      chk($sformatf("tbl%0d_count", i), int'(cnt), tbl[i].q);
      chk($sformatf("tbl%0d_edges", i), int'(ecnt), tbl[i].e);
      chk($sformatf("tbl%0d_pins", i), rd_pins(), int'(tbl[i].pins));
    end

    // Clear arriving together with an accepted edge at Q = 7
    drive(1, 0, 1, 1, 4'h7, 3'd0);
    pulse(20);
    chk("load7_count", int'(cnt), 7);
    @(negedge clk);
    p1 = 1'b0;
    p2 = 1'b1;
    wait_n(20);
    p2 = 1'b0;
    wait_n(20);
    chk("clr_edge_count", int'(cnt), 0);
    chk("clr_edge_edges", int'(ecnt), 23);

    // Edge latency: Q at +7 cycles, pins at +8
    drive(1, 1, 1, 1, 4'h0, 3'd0);
    p2 = 1'b1;
    wait_n(6);
    chk("lat6_count", int'(cnt), 0);
    wait_n(1);
    chk("lat7_count", int'(cnt), 1);
    chk("lat7_edges", int'(ecnt), 24);
    chk("lat7_pins", rd_pins(), 0);
    wait_n(1);
    chk("lat8_pins", rd_pins(), 1);
    wait_n(12);
    p2 = 1'b0;
    wait_n(20);

    // Ten 2-cycle glitches
    for (int g = 0; g < 10; g++) begin
      p2 = 1'b1;
      wait_n(2);
      p2 = 1'b0;
      wait_n(10);
    end
    chk("glitch_count", int'(cnt), 1);
    chk("glitch_edges", int'(ecnt), 24);

    // Output enable
    chk("en1_pins", rd_pins(), 1);
    en = 1'b0;
    wait_n(3);
    chk("en0_pins_z", rd_pins(), 31);
    en = 1'b1;
    wait_n(3);
    chk("en1b_pins", rd_pins(), 1);

    // Asynchronous reset mid-count at Q = 9
    drive(1, 0, 1, 1, 4'h9, 3'd0);
    pulse(20);
    chk("load9_count", int'(cnt), 9);
    p2 = 1'b1;
    wait_n(3);
    #5 rst_n = 1'b0;
    #1;
    chk("async_rst_count", int'(cnt), 0);
    chk("async_rst_edges", int'(ecnt), 0);
    wait_n(3);
    rst_n = 1'b1;
    wait_n(20);
    chk("rearm_count", int'(cnt), 0);
    chk("rearm_edges", int'(ecnt), 0);
    chk("rearm_pins", rd_pins(), 0);
    p2 = 1'b0;
    wait_n(20);
    drive(1, 1, 1, 1, 4'h0, 3'd0);
    pulse(20);
    chk("post_rst_count", int'(cnt), 1);
    chk("post_rst_edges", int'(ecnt), 1);

    // Randomized phase against the behavioural model
    m_q = 1;
    m_e = 1;
    for (int r = 0; r < 40; r++) begin
      bit         clr, ld, enp, ent;
      logic [3:0] d;
      logic [2:0] f;
      int         h;
      clr = ($urandom_range(0, 7) != 0);
      ld  = ($urandom_range(0, 3) == 0);
      enp = 1'($urandom_range(0, 1));
      ent = 1'($urandom_range(0, 1));
      d   = 4'($urandom_range(0, 15));
      f   = 3'($urandom_range(0, 7));
      h   = hw[$urandom_range(0, 4)];
      drive(clr, ld, enp, ent, d, f);
      pulse(h);
      if (!clr) m_q = 0;
      if (h >= c_FILT) begin
        m_e = (m_e + 1) % 256;
        if (clr) begin
          if (!ld) m_q = int'(d);
          else if (enp && ent) m_q = (m_q + ((f == 3'd4) ? 2 : 1)) % 16;
        end
      end
      chk($sformatf("rnd%0d_count", r), int'(cnt), m_q);
      chk($sformatf("rnd%0d_edges", r), int'(ecnt), m_e);
      chk($sformatf("rnd%0d_pins", r), rd_pins(), exp_pins(m_q, ent, int'(f)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
